// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and pipeline-control unit for the 5-stage RISC-V core.
// Handles redirect flush windows, load-use stalls, multi-cycle EX ops with timeout, and perf counters.
module hazard_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_id_ex,
  input  logic [REG_AW-1:0] rs2_id_ex,
  input  logic [REG_AW-1:0] rd_ex_mem,
  input  logic [REG_AW-1:0] rd_mem_wb,
  input  logic              reg_write_ex_mem,
  input  logic              reg_write_mem_wb,
  input  logic              mem_read_id_ex,
  input  logic [REG_AW-1:0] rd_id_ex,
  input  logic [REG_AW-1:0] rs1_if_id,
  input  logic [REG_AW-1:0] rs2_if_id,
  input  logic              branch_taken,
  input  logic              jump_ex_mem,
  input  logic              mc_start,
  input  logic              mc_done,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              pc_write,
  output logic              retain_if_id,
  output logic              retain_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              mc_kill,
  output logic              mc_timeout_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_BUSY  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t            state_reg;
  logic [FC_W-1:0]   flush_left_reg;
  logic [TO_W-1:0]   mc_age_reg;
  logic              timeout_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  // ---------------------------------------------------------------
  // Operand forwarding: EX/MEM has priority, x0 never forwarded.
  // ---------------------------------------------------------------
  logic [REG_AW-1:0] rs_ex [2];
  logic [1:0]        fwd_sel [2];

  assign rs_ex[0] = rs1_id_ex;
  assign rs_ex[1] = rs2_id_ex;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (reg_write_ex_mem && (rd_ex_mem != '0) && (rd_ex_mem == rs_ex[gi])) begin
          fwd_sel[gi] = 2'b10;
        end else if (reg_write_mem_wb && (rd_mem_wb != '0) && (rd_mem_wb == rs_ex[gi])) begin
          fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign forward_A = fwd_sel[0];
  assign forward_B = fwd_sel[1];

  // ---------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------
  logic redirect;
  logic load_use;
  logic mc_expire;

  assign redirect  = branch_taken | jump_ex_mem;
  assign load_use  = mem_read_id_ex && (rd_id_ex != '0) &&
                     ((rd_id_ex == rs1_if_id) || (rd_id_ex == rs2_if_id));
  assign mc_expire = (mc_age_reg == TO_W'(MC_TIMEOUT - 1));

  // ---------------------------------------------------------------
  // Control decode. Responses (flush, stall, kill) must take effect in
  // the same cycle the event is seen, so they come from state + inputs.
  // ---------------------------------------------------------------
  logic pc_write_next;
  logic retain_if_id_next;
  logic retain_id_ex_next;
  logic flush_if_id_next;
  logic flush_id_ex_next;
  logic flush_ex_mem_next;
  logic mc_kill_next;
  logic stall_evt;
  logic flush_evt;

  always_comb begin
    pc_write_next     = 1'b1;
    retain_if_id_next = 1'b0;
    retain_id_ex_next = 1'b0;
    flush_if_id_next  = 1'b0;
    flush_id_ex_next  = 1'b0;
    flush_ex_mem_next = 1'b0;
    mc_kill_next      = 1'b0;
    stall_evt         = 1'b0;
    flush_evt         = 1'b0;

    if (rst) begin
      pc_write_next = 1'b1;
    end else if (redirect) begin
      flush_if_id_next  = 1'b1;
      flush_id_ex_next  = 1'b1;
      flush_ex_mem_next = 1'b1;
      flush_evt         = 1'b1;
      mc_kill_next      = (state_reg == ST_MC_BUSY);
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (load_use) begin
            pc_write_next     = 1'b0;
            retain_if_id_next = 1'b1;
            flush_id_ex_next  = 1'b1;
            stall_evt         = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          if (!mc_done) begin
            pc_write_next     = 1'b0;
            retain_if_id_next = 1'b1;
            retain_id_ex_next = 1'b1;
            flush_ex_mem_next = 1'b1;
            stall_evt         = 1'b1;
            mc_kill_next      = mc_expire;
          end
        end
        ST_REDIRECT: begin
          flush_if_id_next  = 1'b1;
          flush_id_ex_next  = 1'b1;
          flush_ex_mem_next = 1'b1;
        end
        default: begin
          pc_write_next = 1'b1;
        end
      endcase
    end
  end

  assign pc_write       = pc_write_next;
  assign retain_if_id   = retain_if_id_next;
  assign retain_id_ex   = retain_id_ex_next;
  assign flush_if_id    = flush_if_id_next;
  assign flush_id_ex    = flush_id_ex_next;
  assign flush_ex_mem   = flush_ex_mem_next;
  assign mc_kill        = mc_kill_next;
  assign mc_timeout_err = timeout_err_reg;
  assign stall_cnt      = stall_cnt_reg;
  assign flush_cnt      = flush_cnt_reg;

  // ---------------------------------------------------------------
  // State, window/timeout counters, sticky error, perf counters
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      flush_left_reg  <= '0;
      mc_age_reg      <= '0;
      timeout_err_reg <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush_evt && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end

      if (redirect) begin
        // The detecting cycle is the first flush cycle; REDIRECT covers the rest.
        if (FLUSH_CYCLES > 1) begin
          state_reg      <= ST_REDIRECT;
          flush_left_reg <= FC_W'(FLUSH_CYCLES - 1);
        end else begin
          state_reg      <= ST_RUN;
          flush_left_reg <= '0;
        end
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (mc_start) begin
              state_reg  <= ST_MC_BUSY;
              mc_age_reg <= '0;
            end
          end
          ST_MC_BUSY: begin
            if (mc_done) begin
              state_reg <= ST_RUN;
            end else if (mc_expire) begin
              state_reg       <= ST_RUN;
              timeout_err_reg <= 1'b1;
            end else begin
              mc_age_reg <= mc_age_reg + 1'b1;
            end
          end
          ST_REDIRECT: begin
            flush_left_reg <= flush_left_reg - 1'b1;
            if (flush_left_reg <= FC_W'(1)) begin
              state_reg <= ST_RUN;
            end
          end
          default: begin
            state_reg <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised, stateful successor to the combinational hazard/forwarding unit of the 5-stage RISC-V pipeline. It keeps EX-stage operand forwarding, load-use stalls and branch/jump flushes. It adds three things: a multi-cycle EX handshake (mul/div) with timeout, a configurable-length redirect flush window, and saturating stall/flush performance counters. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their retain/flush controls and the PC write enable.

Parameters:
REG_AW, 5, register address width
FLUSH_CYCLES, 1, cycles the redirect flush is held (>=1)
MC_TIMEOUT, 64, max MC_BUSY cycles before forced abort (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs1_id_ex, rs2_id_ex  in  REG_AW  EX-stage source registers
rd_ex_mem, rd_mem_wb  in  REG_AW  destination registers in MEM and WB
reg_write_ex_mem, reg_write_mem_wb  in  1  register write enables in MEM and WB
mem_read_id_ex  in  1  EX-stage instruction is a load
rd_id_ex  in  REG_AW  EX-stage destination register
rs1_if_id, rs2_if_id  in  REG_AW  ID-stage source registers
branch_taken, jump_ex_mem  in  1  control-flow redirect resolved in MEM
mc_start  in  1  multi-cycle op issued in EX (single-cycle pulse)
mc_done  in  1  multi-cycle unit result valid
forward_A, forward_B  out  2  00 = regfile, 10 = EX/MEM, 01 = MEM/WB
pc_write  out  1  PC update enable
retain_if_id, retain_id_ex  out  1  hold pipeline register
flush_if_id, flush_id_ex, flush_ex_mem  out  1  bubble pipeline register
mc_kill  out  1  abort the multi-cycle unit (1-cycle pulse)
mc_timeout_err  out  1  sticky; set on timeout
stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Forwarding (combinational, all states):
  - EX/MEM match (reg_write, rd!=0, rd==rs) → 10.
  - Otherwise MEM/WB match → 01.
  - Otherwise 00.
  - EX/MEM wins over MEM/WB. Register x0 is never forwarded.
- FSM states: RUN, MC_BUSY, REDIRECT. Reset → RUN.
- Reset outputs: pc_write=1, every retain/flush=0, mc_kill=0, mc_timeout_err=0, counters=0. Counter values are irrelevant during rst.
- Default outputs (RUN, no event): pc_write=1, all retain/flush=0.
- Redirect (branch_taken | jump_ex_mem), highest priority in any state:
  - Same cycle: flush_if_id=flush_id_ex=flush_ex_mem=1, pc_write=1.
  - Next cycle: enter REDIRECT with flush counter = FLUSH_CYCLES-1.
  - REDIRECT holds all three flushes while the counter is nonzero, decrementing each cycle. When it reaches 0, return to RUN.
  - With FLUSH_CYCLES=1 the flush lasts exactly the detecting cycle and REDIRECT is skipped.
  - A new redirect inside REDIRECT reloads the counter.
  - A redirect in MC_BUSY pulses mc_kill for 1 cycle and discards the MC op.
  - flush_cnt += 1 per redirect event, not per cycle.
- Load-use (RUN only, no redirect):
  - Condition: mem_read_id_ex & rd_id_ex!=0 & (rd_id_ex==rs1_if_id | rd_id_ex==rs2_if_id).
  - Response: pc_write=0, retain_if_id=1, flush_id_ex=1 for exactly that cycle.
  - stall_cnt += 1.
- Multi-cycle op:
  - mc_start in RUN (no redirect) → MC_BUSY next cycle; the timeout counter loads 0.
  - MC_BUSY: pc_write=0, retain_if_id=1, retain_id_ex=1, flush_ex_mem=1. stall_cnt += 1 per cycle.
  - mc_done in MC_BUSY: outputs revert to default in that same cycle; RUN next cycle.
  - mc_start together with a load-use hazard: the load-use response applies that cycle, then MC_BUSY.
  - Timeout: if the counter reaches MC_TIMEOUT-1 without mc_done → mc_kill 1-cycle pulse, mc_timeout_err set (cleared only by rst), RUN next cycle.
  - mc_done outside MC_BUSY is ignored.
- Counters saturate at 2^CNT_W-1; they never wrap.
- rst mid-operation (any state) → RUN next cycle. mc_kill is not asserted on reset.

Test Plan:
- rs1_id_ex=5, rd_ex_mem=5, reg_write_ex_mem=1, rd_mem_wb=5, reg_write_mem_wb=1 → forward_A=10. With rd_ex_mem=0 → forward_A=01. With all rd=0 → 00.
- mem_read_id_ex=1, rd_id_ex=6, rs2_if_id=6 → one cycle of pc_write=0, retain_if_id=1, flush_id_ex=1; stall_cnt=1. Same with rd_id_ex=0 → no stall.
- mc_start pulse, mc_done after 4 cycles → 4 cycles of MC_BUSY stall outputs, then defaults; stall_cnt=4.
- FLUSH_CYCLES=3, branch_taken pulse → 3 consecutive cycles of all three flushes with pc_write=1; flush_cnt=1. A second pulse in cycle 2 extends the flush to cycle 4; flush_cnt=2.
- MC_TIMEOUT=8, mc_done never asserted → mc_kill pulse after 8 busy cycles, mc_timeout_err=1 and stays set until rst.
- jump_ex_mem during MC_BUSY → mc_kill pulse and flushes the same cycle. rst asserted inside REDIRECT → RUN with all outputs at reset values the next cycle.
